// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/response bus between fetch unit and memory
interface instr_fetch_unit_if #(
   parameter int WIDTH = 32
);
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [WIDTH-1:0] imem_req_addr;
   logic             imem_rsp_valid;
   logic [WIDTH-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC fetch stage with one outstanding imem request and a 2-entry instruction FIFO
module instr_fetch_unit #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst,
   instr_fetch_unit_if.master  imem,
   input  logic                i_redirect_valid,
   input  logic [WIDTH-1:0]    i_redirect_pc,
   output logic                o_instr_valid,
   output logic [WIDTH-1:0]    o_instr,
   output logic [WIDTH-1:0]    o_instr_pc,
   input  logic                i_instr_ready
);
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_fetch_pc;
   logic [WIDTH-1:0] r_pend_pc;
   logic [WIDTH-1:0] r_fifo_data [2];
   logic [WIDTH-1:0] r_fifo_pc   [2];
   logic             r_rd_ptr;
   logic             r_wr_ptr;
   logic [1:0]       r_count;

   logic             w_req_valid;
   logic             w_req_fire;
   logic             w_push;
   logic             w_pop;
   logic             w_head_valid;

   // Issue is gated on FIFO space so a returning word always has a slot.
   assign w_req_valid  = ~rst & (r_state == S_REQ) & (r_count < 2'd2) & ~i_redirect_valid;
   assign w_req_fire   = w_req_valid & imem.imem_req_ready;
   assign w_push       = (r_state == S_WAIT) & imem.imem_rsp_valid;
   assign w_head_valid = (r_count != 2'd0);
   assign w_pop        = w_head_valid & i_instr_ready;

   assign imem.imem_req_valid = w_req_valid;
   assign imem.imem_req_addr  = r_fetch_pc;

   assign o_instr_valid = w_head_valid;
   assign o_instr       = w_head_valid ? r_fifo_data[r_rd_ptr] : NOP_INSTR;
   assign o_instr_pc    = w_head_valid ? r_fifo_pc[r_rd_ptr]   : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_REQ;
         r_fetch_pc <= RESET_PC;
         r_pend_pc  <= '0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else if (i_redirect_valid) begin
         // A redirect flushes everything; an in-flight request becomes stale unless it lands now.
         r_fetch_pc <= {i_redirect_pc[WIDTH-1:2], 2'b00};
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
         case (r_state)
            S_WAIT, S_DROP: r_state <= imem.imem_rsp_valid ? S_REQ : S_DROP;
            default:        r_state <= S_REQ;
         endcase
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_req_fire) begin
                  r_state   <= S_WAIT;
                  r_pend_pc <= r_fetch_pc;
               end
            end
            S_WAIT: begin
               if (imem.imem_rsp_valid) begin
                  r_state    <= S_REQ;
                  r_fetch_pc <= r_fetch_pc + WIDTH'(4);
               end
            end
            S_DROP: begin
               if (imem.imem_rsp_valid) begin
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_REQ;
         endcase

         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= imem.imem_rsp_data;
            r_fifo_pc[r_wr_ptr]   <= r_pend_pc;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
